// File: rtl/hm_ctlif_if.sv
// CSR bus between the host-side register master and the hm_ctlif register bank.
// The master drives address, strobe and write data; the slave returns registered read data.
interface hm_ctlif_if;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;

    modport master (output csr_a, output csr_we, output csr_di, input csr_do);
    modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/hm_ctlif.sv
// CSR control block for the host-memory engine: run FSM with start pulse,
// sticky event flags with W1C and interrupt mask, BAR bitmap and write-BAR statistics.
module hm_ctlif #(
    parameter logic [3:0] csr_addr = 4'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    hm_ctlif_if.slave   csr,
    output logic        irq,
    input  logic        sys__rx_timeout,
    input  logic        sys__tx_timeout,
    input  logic        sys__wr_timeout,
    input  logic        sys__hm_end,
    input  logic        sys__write_bar,
    input  logic        sys__read_exp,
    input  logic        sys__trn_lnk_up_n,
    input  logic [1:0]  sys__state,
    input  logic [2:0]  sys__state_rx,
    input  logic [1:0]  sys__state_tx,
    input  logic [31:0] sys__rx_tlp_dw,
    input  logic [4:0]  sys__write_bar_number,
    output logic [31:0] sys__bar_bitmap,
    output logic        sys__hm_start_read
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } run_state_e;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_EVENT    = 3'd1;
    localparam logic [2:0] REG_IRQ_EN   = 3'd2;
    localparam logic [2:0] REG_BAR_MAP  = 3'd3;
    localparam logic [2:0] REG_LAST_BAR = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;
    localparam logic [2:0] REG_RX_DW    = 3'd6;
    localparam logic [2:0] REG_WR_CNT   = 3'd7;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    run_state_e  state_q, state_d;
    logic        sel, wr_en, ctrl_wr;
    logic [2:0]  idx;
    logic        start_ok, abort_set, timeout_any;
    logic        abort_q;
    logic [5:0]  ev_q, ev_pulse, ev_clr;
    logic [5:0]  irq_en_q;
    logic [31:0] bar_q;
    logic [4:0]  last_bar_q;
    logic [31:0] wr_cnt_q;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    assign sel         = (csr.csr_a[13:10] == csr_addr);
    assign idx         = csr.csr_a[2:0];
    assign wr_en       = sel && csr.csr_we;
    assign ctrl_wr     = wr_en && (idx == REG_CTRL);
    assign timeout_any = sys__rx_timeout | sys__tx_timeout | sys__wr_timeout;
    assign unused_addr_bits = &{1'b0, csr.csr_a[9:3]};

    assign ev_pulse = {sys__read_exp, sys__write_bar, sys__hm_end,
                       sys__wr_timeout, sys__tx_timeout, sys__rx_timeout};
    assign ev_clr   = (wr_en && (idx == REG_EVENT)) ? csr.csr_di[5:0] : 6'd0;

    assign sys__bar_bitmap = bar_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Start is only accepted from IDLE with the link up; link loss in RUN is remembered as an abort.
    always_comb begin
        state_d            = state_q;
        sys__hm_start_read = 1'b0;
        start_ok           = 1'b0;
        abort_set          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_wr && csr.csr_di[0] && !sys__trn_lnk_up_n) begin
                    state_d  = S_START;
                    start_ok = 1'b1;
                end
            end
            S_START: begin
                sys__hm_start_read = 1'b1;
                state_d            = S_RUN;
            end
            S_RUN: begin
                if (sys__trn_lnk_up_n) begin
                    state_d   = S_IDLE;
                    abort_set = 1'b1;
                end else if (sys__hm_end || timeout_any) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (idx)
            REG_CTRL:     rd_mux = {30'd0, abort_q, (state_q != S_IDLE)};
            REG_EVENT:    rd_mux = {26'd0, ev_q};
            REG_IRQ_EN:   rd_mux = {26'd0, irq_en_q};
            REG_BAR_MAP:  rd_mux = bar_q;
            REG_LAST_BAR: rd_mux = {27'd0, last_bar_q};
            REG_STATUS:   rd_mux = {23'd0, sys__trn_lnk_up_n, sys__state_tx,
                                    sys__state_rx, 1'b0, sys__state};
            REG_RX_DW:    rd_mux = sys__rx_tlp_dw;
            REG_WR_CNT:   rd_mux = wr_cnt_q;
            default:      rd_mux = 32'd0;
        endcase
    end

    // Register bank; an event pulse wins over a same-cycle W1C, a counter write wins over a pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            abort_q    <= 1'b0;
            ev_q       <= 6'd0;
            irq_en_q   <= 6'd0;
            bar_q      <= 32'd0;
            last_bar_q <= 5'd0;
            wr_cnt_q   <= 32'd0;
            irq        <= 1'b0;
            csr.csr_do <= 32'd0;
        end else begin
            if (start_ok)       abort_q <= 1'b0;
            else if (abort_set) abort_q <= 1'b1;

            ev_q <= (ev_q & ~ev_clr) | ev_pulse;

            if (wr_en && (idx == REG_IRQ_EN))  irq_en_q <= csr.csr_di[5:0];
            if (wr_en && (idx == REG_BAR_MAP)) bar_q    <= csr.csr_di;

            if (sys__write_bar) last_bar_q <= sys__write_bar_number;

            if (wr_en && (idx == REG_WR_CNT)) wr_cnt_q <= 32'd0;
            else if (sys__write_bar)          wr_cnt_q <= sat_inc(wr_cnt_q);

            irq        <= |(ev_q & irq_en_q);
            csr.csr_do <= sel ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_hm_ctlif.sv
// Bench for hm_ctlif: directed scenarios with literal expectations plus randomized traffic,
// all outputs compared every cycle against a register-map level model.
module tb_hm_ctlif;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        irq, hm_start_read;
    logic [31:0] bar_bitmap;
    logic        p_rx = 0, p_tx = 0, p_wr = 0, p_end = 0, p_wb = 0, p_re = 0;
    logic        lnk_n = 0;
    logic [1:0]  st = 0;
    logic [2:0]  st_rx = 0;
    logic [1:0]  st_tx = 0;
    logic [31:0] rx_dw = 0;
    logic [4:0]  wb_num = 0;

    int n_cmp = 0;
    int n_fail = 0;

    hm_ctlif_if csr ();

    hm_ctlif #(.csr_addr(4'h0)) dut (
        .sys_clk               (sys_clk),
        .sys_rst_n             (sys_rst_n),
        .csr                   (csr),
        .irq                   (irq),
        .sys__rx_timeout       (p_rx),
        .sys__tx_timeout       (p_tx),
        .sys__wr_timeout       (p_wr),
        .sys__hm_end           (p_end),
        .sys__write_bar        (p_wb),
        .sys__read_exp         (p_re),
        .sys__trn_lnk_up_n     (lnk_n),
        .sys__state            (st),
        .sys__state_rx         (st_rx),
        .sys__state_tx         (st_tx),
        .sys__rx_tlp_dw        (rx_dw),
        .sys__write_bar_number (wb_num),
        .sys__bar_bitmap       (bar_bitmap),
        .sys__hm_start_read    (hm_start_read)
    );

    always #5 sys_clk = ~sys_clk;

    // Model state: what the register map must hold, plus expected registered outputs.
    bit        m_busy, m_first, m_abort, m_irq;
    bit [5:0]  m_ev, m_en;
    bit [31:0] m_bar, m_cnt, m_do;
    bit [4:0]  m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task model_reset();
        m_busy = 0; m_first = 0; m_abort = 0; m_irq = 0;
        m_ev = 0; m_en = 0; m_bar = 0; m_cnt = 0; m_do = 0; m_last = 0;
    endtask

    task model_edge();
        bit        sel, wr;
        bit [2:0]  idx;
        bit [31:0] rd;
        bit [5:0]  pulses, clr;
        sel    = (csr.csr_a[13:10] == 4'h0);
        idx    = csr.csr_a[2:0];
        wr     = sel && csr.csr_we;
        pulses = {p_re, p_wb, p_end, p_wr, p_tx, p_rx};
        case (idx)
            3'd0: rd = {30'd0, m_abort, m_busy};
            3'd1: rd = {26'd0, m_ev};
            3'd2: rd = {26'd0, m_en};
            3'd3: rd = m_bar;
            3'd4: rd = {27'd0, m_last};
            3'd5: rd = 32'(lnk_n) * 256 + 32'(st_tx) * 64 + 32'(st_rx) * 8 + 32'(st);
            3'd6: rd = rx_dw;
            default: rd = m_cnt;
        endcase
        m_do  = sel ? rd : 32'd0;
        m_irq = |(m_ev & m_en);

        if (!m_busy) begin
            if (wr && idx == 3'd0 && csr.csr_di[0] && !lnk_n) begin
                m_busy = 1; m_first = 1; m_abort = 0;
            end
        end else if (m_first) begin
            m_first = 0;
        end else if (lnk_n) begin
            m_busy = 0; m_abort = 1;
        end else if (p_end || p_rx || p_tx || p_wr) begin
            m_busy = 0;
        end

        clr  = (wr && idx == 3'd1) ? csr.csr_di[5:0] : 6'd0;
        m_ev = (m_ev & ~clr) | pulses;
        if (wr && idx == 3'd2) m_en  = csr.csr_di[5:0];
        if (wr && idx == 3'd3) m_bar = csr.csr_di;
        if (p_wb) m_last = wb_num;
        if (wr && idx == 3'd7) m_cnt = 0;
        else if (p_wb && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endtask

    // One clock: model advances on the edge, all outputs compared 1 time unit later.
    task step();
        @(posedge sys_clk);
        model_edge();
        #1;
        check("csr_do", csr.csr_do, m_do);
        check("irq", 32'(irq), 32'(m_irq));
        check("start_read", 32'(hm_start_read), 32'(m_first));
        check("bar_bitmap", bar_bitmap, m_bar);
        csr.csr_we = 0;
        {p_re, p_wb, p_end, p_wr, p_tx, p_rx} = 6'd0;
    endtask

    task wr(input logic [2:0] idx, input logic [31:0] data);
        csr.csr_a = {11'd0, idx}; csr.csr_we = 1; csr.csr_di = data;
        step();
    endtask

    task rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
        csr.csr_a = {11'd0, idx}; csr.csr_we = 0;
        step();
        check(name, csr.csr_do, exp);
    endtask

    task do_reset();
        sys_rst_n = 0;
        #1;
        check("rst_csr_do", csr.csr_do, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_start_read", 32'(hm_start_read), 32'd0);
        check("rst_bar_bitmap", bar_bitmap, 32'd0);
        model_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1;
    endtask

    initial begin
        logic [3:0] hi;
        csr.csr_a = 0; csr.csr_we = 0; csr.csr_di = 0;
        #2;
        do_reset();

        // Reset contents of every register
        for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, "reset_reg");

        // Live STATUS / RX_DW
        st = 2'b11; st_rx = 3'b101; st_tx = 2'b10; lnk_n = 1; rx_dw = 32'hDEADBEEF;
        rd(3'd5, 32'h0000_01AB, "status_live");
        rd(3'd6, 32'hDEADBEEF, "rx_dw_live");
        st = 0; st_rx = 0; st_tx = 0; lnk_n = 0;

        // Other bank select: no read data, write ignored
        csr.csr_a = 14'h0403; csr.csr_we = 1; csr.csr_di = 32'hFFFF_FFFF;
        step();
        check("unselected_read", csr.csr_do, 32'd0);
        rd(3'd3, 32'd0, "unselected_write");

        // Start, single pulse, busy, end event
        wr(3'd0, 32'd1);
        check("start_pulse", 32'(hm_start_read), 32'd1);
        step();
        check("start_pulse_end", 32'(hm_start_read), 32'd0);
        rd(3'd0, 32'd1, "busy");
        p_end = 1; step();
        rd(3'd0, 32'd0, "idle_after_end");
        rd(3'd1, 32'h08, "event_hm_end");
        wr(3'd1, 32'h3F);

        // Interrupt mask and W1C
        wr(3'd2, 32'h01);
        p_rx = 1; step();
        step();
        check("irq_set", 32'(irq), 32'd1);
        wr(3'd1, 32'h01);
        step();
        check("irq_clear", 32'(irq), 32'd0);
        rd(3'd1, 32'd0, "event_cleared");

        // Start refused with link down; link loss during RUN
        lnk_n = 1;
        wr(3'd0, 32'd1);
        check("no_pulse_link_down", 32'(hm_start_read), 32'd0);
        rd(3'd0, 32'd0, "not_busy_link_down");
        lnk_n = 0;
        wr(3'd0, 32'd1);
        step();
        lnk_n = 1; step();
        rd(3'd0, 32'd2, "link_abort_flag");
        lnk_n = 0;

        // Write-BAR capture and counter
        wr(3'd7, 32'd0);
        for (int i = 0; i < 3; i++) begin
            p_wb = 1; wb_num = 5'd5; step();
        end
        rd(3'd4, 32'd5, "last_bar");
        rd(3'd7, 32'd3, "wr_cnt");
        rd(3'd1, 32'h10, "event_write_bar");
        wr(3'd7, 32'h1234);
        rd(3'd7, 32'd0, "wr_cnt_cleared");
        p_wb = 1; wr(3'd7, 32'd0);
        rd(3'd7, 32'd0, "wr_cnt_write_wins");

        // Pulse beats same-cycle clear
        wr(3'd1, 32'h3F);
        p_tx = 1; wr(3'd1, 32'h3F);
        rd(3'd1, 32'h02, "w1c_vs_pulse");

        // Bitmap output, then async reset in the middle of a run
        wr(3'd3, 32'hA5A5A5A5);
        check("bar_bitmap_out", bar_bitmap, 32'hA5A5A5A5);
        p_rx = 1; step();
        wr(3'd0, 32'd1);
        step();
        rd(3'd3, 32'hA5A5A5A5, "bitmap_readback");
        check("irq_before_reset", 32'(irq), 32'd1);
        do_reset();
        step();
        rd(3'd0, 32'd0, "idle_after_reset");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            hi = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            csr.csr_a  = {hi, 7'($urandom), 3'($urandom)};
            csr.csr_we = ($urandom_range(0, 2) == 0);
            csr.csr_di = $urandom;
            p_rx  = ($urandom_range(0, 15) == 0);
            p_tx  = ($urandom_range(0, 15) == 0);
            p_wr  = ($urandom_range(0, 15) == 0);
            p_end = ($urandom_range(0, 15) == 0);
            p_wb  = ($urandom_range(0, 7) == 0);
            p_re  = ($urandom_range(0, 15) == 0);
            lnk_n = lnk_n ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 60) == 0);
            st = 2'($urandom); st_rx = 3'($urandom); st_tx = 2'($urandom);
            rx_dw = $urandom; wb_num = 5'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hm_ctlif.md
HM_CTLIF -- requirements
Module: hm_ctlif

Interface
REQ-001 csr_addr, 4'h0, CSR bank select; the block responds only when csr_a[13:10] == csr_addr.
REQ-002 sys_clk  in  1  sole clock; all logic samples on its rising edge.
REQ-003 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-004 csr_a  in  14  CSR address; register index = csr_a[2:0].
REQ-005 csr_we  in  1  write strobe, one cycle.
REQ-006 csr_di  in  32  write data.
REQ-007 csr_do  out  32  read data, registered.
REQ-008 irq  out  1  level interrupt.
REQ-009 sys__rx_timeout, sys__tx_timeout, sys__wr_timeout, sys__hm_end, sys__write_bar, sys__read_exp  in  1 each  single-cycle event pulses, already synchronised.
REQ-010 sys__trn_lnk_up_n  in  1  link down when 1, level.
REQ-011 sys__state  in  2; sys__state_rx  in  3; sys__state_tx  in  2  engine state snapshots.
REQ-012 sys__rx_tlp_dw  in  32  last received TLP dword.
REQ-013 sys__write_bar_number  in  5  BAR index qualifying sys__write_bar.
REQ-014 sys__bar_bitmap  out  32  BAR enable bitmap.
REQ-015 sys__hm_start_read  out  1  one-cycle start pulse.

Function
REQ-016 Register map by index: 0 CTRL, 1 EVENT, 2 IRQ_EN, 3 BAR_BITMAP, 4 LAST_BAR, 5 STATUS, 6 RX_DW, 7 WR_CNT.
REQ-017 Read: csr_do = selected register one cycle after csr_a is presented when selected, else 0; unused bits read 0.
REQ-018 Run FSM states: IDLE, START, RUN.
  - IDLE -> START on CTRL write with csr_di[0]=1 and sys__trn_lnk_up_n=0.
  - START -> RUN unconditionally after 1 cycle; sys__hm_start_read=1 only while in START.
  - RUN -> IDLE on sys__hm_end, any timeout pulse, or sys__trn_lnk_up_n=1.
REQ-019 CTRL writes in START or RUN, or with link down, are ignored: no pulse, no state change.
REQ-020 CTRL read: bit0 = busy (state != IDLE); bit1 = link-abort flag (set on RUN->IDLE caused by link down, cleared by next accepted start).
REQ-021 EVENT bits [5:0] = rx_timeout, tx_timeout, wr_timeout, hm_end, write_bar, read_exp; each bit is sticky-set by its pulse.
REQ-022 EVENT write clears bits whose csr_di bit = 1 (W1C); a same-cycle pulse and clear on one bit leaves it set.
REQ-023 IRQ_EN[5:0] R/W mask, reset 0.
REQ-024 irq registered: irq = |(EVENT & IRQ_EN), visible one cycle after the flag/mask change.
REQ-025 BAR_BITMAP R/W; sys__bar_bitmap is driven directly from this register.
REQ-026 LAST_BAR[4:0] captures sys__write_bar_number on each sys__write_bar pulse.
REQ-027 STATUS read = {23'b0, lnk_up_n[8], state_tx[7:6], state_rx[5:3], state[1:0]} with bit2 = 0, sampled live.
REQ-028 RX_DW reads sys__rx_tlp_dw live.
REQ-029 WR_CNT increments on each sys__write_bar pulse and saturates at 32'hFFFFFFFF; any write to WR_CNT sets it to 0; a simultaneous pulse and write results in 0.
REQ-030 Writes to read-only registers (4, 5, 6) have no effect.

Reset
REQ-031 sys_rst_n low forces, asynchronously: FSM IDLE, CTRL flag 0, EVENT 0, IRQ_EN 0, BAR_BITMAP 0, LAST_BAR 0, WR_CNT 0, csr_do 0, irq 0, sys__hm_start_read 0.
REQ-032 Reset asserted in START or RUN aborts the run; no pulse is emitted after reset deasserts.

Verification
REQ-033 Link up, write CTRL=1 -> hm_start_read high exactly one cycle; busy=1; sys__hm_end pulse -> busy=0, EVENT=0x08.
REQ-034 Set IRQ_EN=0x01, pulse rx_timeout -> irq=1 next cycle; write EVENT=0x01 -> irq=0; EVENT=0.
REQ-035 Link down (lnk_up_n=1), write CTRL=1 -> no pulse, busy=0; link drops during RUN -> IDLE, CTRL reads 0x2.
REQ-036 write_bar pulse with number 5, repeated 3 times -> LAST_BAR=5, WR_CNT=3, EVENT bit4 set; write WR_CNT -> 0.
REQ-037 Same-cycle EVENT W1C 0x3F and tx_timeout pulse -> EVENT=0x02.
REQ-038 Write BAR_BITMAP=0xA5A5A5A5 -> sys__bar_bitmap matches; assert sys_rst_n=0 mid-RUN -> all outputs 0 immediately.
